xy_stim_gen: RTL and testbench

//  Driving end of the two-bit (x,y) control interface consumed by the three-state sequence FSM.

---
 rtl/xy_stim_if.sv | 25 ++
 rtl/xy_stim_gen.sv | 107 ++++++++++
 tb/tb_xy_stim_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/xy_stim_if.sv
// Control/stimulus bundle between a burst controller and the x/y stimulus generator.
// The generator drives the x/y pattern (master). The controller side supplies start/pause/len (slave).
interface xy_stim_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             i_start;
  logic             i_pause;
  logic [CNT_W-1:0] i_len;
  logic             o_x;
  logic             o_y;
  logic             o_valid;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_cycle;

  modport master (
    input  i_start, i_pause, i_len,
    output o_x, o_y, o_valid, o_busy, o_done, o_cycle
  );

  modport slave (
    output i_start, i_pause, i_len,
    input  o_x, o_y, o_valid, o_busy, o_done, o_cycle
  );
endinterface

// File: rtl/xy_stim_gen.sv
// Burst generator of programmable x/y toggle patterns with a start/pause/done handshake
// and a 0-based cycle index, so a sequence FSM and its checker stay cycle-aligned.
module xy_stim_gen #(
  parameter int unsigned X_DIV  = 1,
  parameter int unsigned Y_DIV  = 5,
  parameter int unsigned CNT_W  = 8,
  parameter bit          X_INIT = 1'b1,
  parameter bit          Y_INIT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  xy_stim_if.master  bus
);

  localparam int unsigned XW = (X_DIV > 1) ? $clog2(X_DIV) : 1;
  localparam int unsigned YW = (Y_DIV > 1) ? $clog2(Y_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [XW-1:0]    xdiv_q, xdiv_d;
  logic [YW-1:0]    ydiv_q, ydiv_d;
  logic             x_q, x_d;
  logic             y_q, y_d;

  logic x_wrap, y_wrap, last;

  assign x_wrap = (xdiv_q == XW'(X_DIV - 1));
  assign y_wrap = (ydiv_q == YW'(Y_DIV - 1));
  assign last   = (cycle_q == len_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cycle_d = cycle_q;
    xdiv_d  = xdiv_q;
    ydiv_d  = ydiv_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.i_start) begin
          state_d = StRun;
          len_d   = bus.i_len;
          cycle_d = '0;
          xdiv_d  = '0;
          ydiv_d  = '0;
          x_d     = X_INIT;
          y_d     = Y_INIT;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (bus.i_pause) begin
          state_d = StHold;
        end else if (last) begin
          // Final burst cycle: no toggle, so DONE shows the last burst levels.
          state_d = StDone;
        end else begin
          cycle_d = cycle_q + CNT_W'(1);
          xdiv_d  = x_wrap ? '0 : xdiv_q + XW'(1);
          if (x_wrap) begin
            x_d    = ~x_q;
            ydiv_d = y_wrap ? '0 : ydiv_q + YW'(1);
            if (y_wrap) y_d = ~y_q;
          end
        end
      end
      StHold: begin
        if (!bus.i_pause) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cycle_q <= '0;
      xdiv_q  <= '0;
      ydiv_q  <= '0;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cycle_q <= cycle_d;
      xdiv_q  <= xdiv_d;
      ydiv_q  <= ydiv_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // o_valid is gated by i_pause directly so it drops in the cycle pause rises.
  assign bus.o_valid = (state_q == StRun) && !bus.i_pause;
  assign bus.o_busy  = (state_q == StRun) || (state_q == StHold);
  assign bus.o_done  = (state_q == StDone);
  assign bus.o_cycle = cycle_q;
  assign bus.o_x     = x_q;
  assign bus.o_y     = y_q;

endmodule

// File: tb/tb_xy_stim_gen.sv
// Directed bench for xy_stim_gen: a per-cycle vector table on a default-parameter instance,
// plus hand sequences for mid-burst reset, full-range burst and a divided-pattern instance.
module tb_xy_stim_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xy_stim_if #(.CNT_W(8)) a_if ();
  xy_stim_if #(.CNT_W(8)) b_if ();

  xy_stim_gen u_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (a_if)
  );

  xy_stim_gen #(.X_DIV(3), .Y_DIV(2)) u_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b_if)
  );

  typedef struct {
    logic       start;
    logic       pause;
    logic [7:0] len;
    logic       valid;
    logic       busy;
    logic       done;
    logic       chk;
    logic [7:0] cyc;
    logic       x;
    logic       y;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(int s, int p, int l, int v, int b, int d,
                              int c, int cy, int x, int y);
    vec_t r;
    r.start = s[0];
    r.pause = p[0];
    r.len   = 8'(l);
    r.valid = v[0];
    r.busy  = b[0];
    r.done  = d[0];
    r.chk   = c[0];
    r.cyc   = 8'(cy);
    r.x     = x[0];
    r.y     = y[0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [12:0] act_w, exp_w;
  logic [11:0] bx, by;
  int          vcnt, seq_err, bad_done;
  logic        seen_done;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    a_if.i_start = 1'b0; a_if.i_pause = 1'b0; a_if.i_len = '0;
    b_if.i_start = 1'b0; b_if.i_pause = 1'b0; b_if.i_len = '0;

    // start, pause, len | valid, busy, done | chk, cycle, x, y
    // Burst of 10 with defaults: x alternates, y flips after the 5th x toggle.
    tbl.push_back(mk(1,0,9, 0,0,0, 1,0,1,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,0,1,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,1,0,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,2,1,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,3,0,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,4,1,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,5,0,0));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,6,1,0));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,7,0,0));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,8,1,0));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,9,0,0));
    tbl.push_back(mk(0,0,9, 0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,9, 0,0,0, 0,0,0,0));
    // Pause for 4 cycles at cycle 3; the HOLD exit cycle is a fifth non-valid cycle.
    tbl.push_back(mk(1,0,9, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,0,1,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,1,0,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,2,1,1));
    tbl.push_back(mk(0,1,9, 0,1,0, 1,3,0,1));
    tbl.push_back(mk(0,1,9, 0,1,0, 1,3,0,1));
    tbl.push_back(mk(0,1,9, 0,1,0, 1,3,0,1));
    tbl.push_back(mk(0,1,9, 0,1,0, 1,3,0,1));
    tbl.push_back(mk(0,0,9, 0,1,0, 1,3,0,1));
    tbl.push_back(mk(0,0,9, 1,1,0, 1,3,0,1));
    // Start in RUN and a new i_len must both be ignored.
    tbl.push_back(mk(1,0,2, 1,1,0, 1,4,1,1));
    tbl.push_back(mk(0,0,2, 1,1,0, 1,5,0,0));
    tbl.push_back(mk(0,0,2, 1,1,0, 1,6,1,0));
    tbl.push_back(mk(0,0,2, 1,1,0, 1,7,0,0));
    tbl.push_back(mk(0,0,2, 1,1,0, 1,8,1,0));
    tbl.push_back(mk(0,0,2, 1,1,0, 1,9,0,0));
    // Start held in DONE: back-to-back burst reloads init levels with no IDLE cycle.
    tbl.push_back(mk(1,0,3, 0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,3, 1,1,0, 1,0,1,1));
    tbl.push_back(mk(0,0,3, 1,1,0, 1,1,0,1));
    tbl.push_back(mk(0,0,3, 1,1,0, 1,2,1,1));
    tbl.push_back(mk(0,0,3, 1,1,0, 1,3,0,1));
    tbl.push_back(mk(0,0,3, 0,0,1, 0,0,0,0));
    // Start with pause in IDLE, len=0: one valid cycle once pause drops.
    tbl.push_back(mk(1,1,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,1,0, 1,0,1,1));
    tbl.push_back(mk(0,0,0, 0,1,0, 1,0,1,1));
    tbl.push_back(mk(0,0,0, 1,1,0, 1,0,1,1));
    tbl.push_back(mk(0,0,0, 0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_a", 32'({a_if.o_valid, a_if.o_busy, a_if.o_done, a_if.o_cycle, a_if.o_x,
                          a_if.o_y}), 32'({3'b000, 8'd0, 2'b11}));
    check("reset_b", 32'({b_if.o_valid, b_if.o_busy, b_if.o_done, b_if.o_cycle, b_if.o_x,
                          b_if.o_y}), 32'({3'b000, 8'd0, 2'b11}));
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      a_if.i_start = tbl[i].start;
      a_if.i_pause = tbl[i].pause;
      a_if.i_len   = tbl[i].len;
      @(negedge clk);
      act_w = {a_if.o_valid, a_if.o_busy, a_if.o_done,
               tbl[i].chk ? {a_if.o_cycle, a_if.o_x, a_if.o_y} : 10'd0};
      exp_w = {tbl[i].valid, tbl[i].busy, tbl[i].done,
               tbl[i].chk ? {tbl[i].cyc, tbl[i].x, tbl[i].y} : 10'd0};
      check($sformatf("row%0d", i), 32'(act_w), 32'(exp_w));
      @(posedge clk); #1;
    end
    a_if.i_start = 1'b0;
    a_if.i_pause = 1'b0;

    // Reset at cycle 5 of a long burst: reset values next cycle, never a done pulse.
    a_if.i_len   = 8'd20;
    a_if.i_start = 1'b1;
    @(posedge clk); #1;
    a_if.i_start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("mid_cycle5", 32'({a_if.o_valid, a_if.o_cycle, a_if.o_x}), 32'({1'b1, 8'd5, 1'b0}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset", 32'({a_if.o_valid, a_if.o_busy, a_if.o_done, a_if.o_cycle, a_if.o_x,
                            a_if.o_y}), 32'({3'b000, 8'd0, 2'b11}));
    bad_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (a_if.o_done || a_if.o_busy) bad_done++;
    end
    check("no_done_after_reset", 32'(bad_done), 32'd0);
    @(posedge clk); #1;

    // Full-range burst: 256 valid cycles, index 0..255 with no wrap, then one done.
    a_if.i_len   = 8'd255;
    a_if.i_start = 1'b1;
    @(posedge clk); #1;
    a_if.i_start = 1'b0;
    vcnt      = 0;
    seq_err   = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      @(negedge clk);
      if (a_if.o_valid) begin
        if (a_if.o_cycle !== 8'(vcnt)) seq_err++;
        vcnt++;
      end
      if (a_if.o_done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    check("full_done_seen", 32'(seen_done), 32'd1);
    check("full_valid_count", 32'(vcnt), 32'd256);
    check("full_cycle_seq", 32'(seq_err), 32'd0);
    @(negedge clk);
    check("full_done_single", 32'({a_if.o_done, a_if.o_busy}), 32'd0);
    @(posedge clk); #1;

    // X_DIV=3, Y_DIV=2, len=11: x flips every 3 valid cycles, y every 6.
    bx = 12'b111000111000;
    by = 12'b111111000000;
    b_if.i_len   = 8'd11;
    b_if.i_start = 1'b1;
    @(posedge clk); #1;
    b_if.i_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("div_k%0d", k),
            32'({b_if.o_valid, b_if.o_cycle, b_if.o_x, b_if.o_y}),
            32'({1'b1, 8'(k), bx[11-k], by[11-k]}));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("div_done", 32'({b_if.o_valid, b_if.o_done}), 32'({1'b0, 1'b1}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
